// File: rtl/types_pkg.sv
// Shared triangle types and wire-format constants for the triangle link
// (transmitter, receiver and benches all import this package).
package types_pkg;

  typedef logic signed [31:0] fixed;

  localparam int FIXED_BITS        = $bits(fixed);
  localparam int COORDS_PER_VERTEX = 3;
  localparam int VERTS_PER_TRI     = 3;
  localparam int WIRE_COLOR_BYTES  = 2;
  localparam int WIRE_FLAG_BYTES   = 1;

  typedef struct packed {
    fixed x;
    fixed y;
    fixed z;
  } position_t;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } color_t;

  typedef struct packed {
    position_t position;
    color_t    color;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef struct packed {
    logic last;
  } triangle_metadata_t;

  // Bytes per triangle on the wire: three vertices of xyz + color, then a flag byte.
  function automatic int triangle_wire_bytes(input int fixed_bytes = FIXED_BITS / 8);
    return VERTS_PER_TRI * (COORDS_PER_VERTEX * fixed_bytes + WIRE_COLOR_BYTES)
           + WIRE_FLAG_BYTES;
  endfunction

endpackage

// File: rtl/triangle_byte_receiver.sv
// Reassembles a byte-serial triangle stream into triangle_t + metadata, writing each
// byte straight into its field slot and double-buffering through one output register.
module triangle_byte_receiver
  import types_pkg::*;
#(
  parameter int FIXED_BYTES = $bits(fixed) / 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output triangle_t          m_triangle,
  output triangle_metadata_t m_metadata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy
);

  if (((FIXED_BITS % 8) != 0) || (FIXED_BYTES * 8 > FIXED_BITS)) begin : g_fixed_width_check
    $error("fixed must be a whole number of bytes and hold FIXED_BYTES bytes");
  end

  localparam int BIDX_W = (FIXED_BYTES > 2) ? $clog2(FIXED_BYTES) : 1;
  localparam logic [BIDX_W-1:0] COORD_LAST_BYTE = BIDX_W'(FIXED_BYTES - 1);

  typedef enum logic [1:0] {
    ST_COORD = 2'd0,
    ST_COLOR = 2'd1,
    ST_FLAG  = 2'd2
  } rx_state_e;

  rx_state_e          state_q, state_d;
  logic [BIDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [1:0]         coord_idx_q, coord_idx_d;
  logic [1:0]         vert_idx_q, vert_idx_d;
  vertex_t            asm_tri_q [VERTS_PER_TRI];
  vertex_t            asm_tri_d [VERTS_PER_TRI];
  triangle_t          m_tri_q, m_tri_d;
  triangle_metadata_t m_meta_q, m_meta_d;
  logic               m_valid_q, m_valid_d;
  logic               busy_q, busy_d;
  logic               accept;

  // Only the flag byte waits for room in the output register.
  always_comb begin
    s_ready = 1'b0;
    if (flush) begin
      s_ready = 1'b0;
    end else if (state_q == ST_FLAG) begin
      s_ready = !m_valid_q || m_ready;
    end else begin
      s_ready = 1'b1;
    end
  end

  assign accept = s_valid && s_ready;

  // Next-state, in-place field assembly and output register load.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    coord_idx_d = coord_idx_q;
    vert_idx_d  = vert_idx_q;
    asm_tri_d   = asm_tri_q;
    m_tri_d     = m_tri_q;
    m_meta_d    = m_meta_q;
    m_valid_d   = m_valid_q && !m_ready;

    if (flush) begin
      state_d     = ST_COORD;
      byte_idx_d  = '0;
      coord_idx_d = 2'd0;
      vert_idx_d  = 2'd0;
    end else if (accept) begin
      case (state_q)
        ST_COORD: begin
          case (coord_idx_q)
            2'd0:    asm_tri_d[vert_idx_q].position.x[{byte_idx_q, 3'b000} +: 8] = s_data;
            2'd1:    asm_tri_d[vert_idx_q].position.y[{byte_idx_q, 3'b000} +: 8] = s_data;
            2'd2:    asm_tri_d[vert_idx_q].position.z[{byte_idx_q, 3'b000} +: 8] = s_data;
            default: asm_tri_d[vert_idx_q] = asm_tri_q[vert_idx_q];
          endcase
          if (byte_idx_q == COORD_LAST_BYTE) begin
            byte_idx_d = '0;
            if (coord_idx_q == 2'd2) begin
              coord_idx_d = 2'd0;
              state_d     = ST_COLOR;
            end else begin
              coord_idx_d = coord_idx_q + 2'd1;
            end
          end else begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end
        end
        ST_COLOR: begin
          if (byte_idx_q == '0) begin
            asm_tri_d[vert_idx_q].color.green = s_data[7:4];
            asm_tri_d[vert_idx_q].color.blue  = s_data[3:0];
            byte_idx_d = BIDX_W'(1);
          end else begin
            // Upper nibble of the color word carries nothing.
            asm_tri_d[vert_idx_q].color.red = s_data[3:0];
            byte_idx_d = '0;
            if (vert_idx_q == 2'd2) begin
              state_d = ST_FLAG;
            end else begin
              vert_idx_d = vert_idx_q + 2'd1;
              state_d    = ST_COORD;
            end
          end
        end
        ST_FLAG: begin
          m_tri_d       = triangle_t'{v0: asm_tri_q[0], v1: asm_tri_q[1], v2: asm_tri_q[2]};
          m_meta_d.last = s_data[0];
          m_valid_d     = 1'b1;
          state_d       = ST_COORD;
          byte_idx_d    = '0;
          coord_idx_d   = 2'd0;
          vert_idx_d    = 2'd0;
        end
        default: begin
          state_d     = ST_COORD;
          byte_idx_d  = '0;
          coord_idx_d = 2'd0;
          vert_idx_d  = 2'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != ST_COORD) || (byte_idx_d != '0) ||
             (coord_idx_d != 2'd0) || (vert_idx_d != 2'd0);
  end

  // State, assembly and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_COORD;
      byte_idx_q  <= '0;
      coord_idx_q <= 2'd0;
      vert_idx_q  <= 2'd0;
      for (int i = 0; i < VERTS_PER_TRI; i++) begin
        asm_tri_q[i] <= '0;
      end
      m_tri_q     <= '0;
      m_meta_q    <= '0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      coord_idx_q <= coord_idx_d;
      vert_idx_q  <= vert_idx_d;
      asm_tri_q   <= asm_tri_d;
      m_tri_q     <= m_tri_d;
      m_meta_q    <= m_meta_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign m_triangle = m_tri_q;
  assign m_metadata = m_meta_q;
  assign m_valid    = m_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_triangle_byte_receiver.sv
// Directed, table-driven bench for triangle_byte_receiver: field mapping, throughput,
// backpressure, flush, mid-triangle reset and gappy s_valid.
module tb_triangle_byte_receiver;
  import types_pkg::*;

  localparam int N = 43;

  logic               clk = 1'b0;
  logic               rstn, flush, s_valid, s_ready, m_valid, m_ready, busy;
  logic [7:0]         s_data;
  triangle_t          m_triangle;
  triangle_metadata_t m_metadata;

  always #5 clk = ~clk;

  triangle_byte_receiver dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_triangle (m_triangle),
    .m_metadata (m_metadata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy)
  );

  typedef struct {
    triangle_t  tri_in;
    logic [3:0] col_junk;
    logic [6:0] flag_junk;
    logic       last_in;
    triangle_t  exp_tri;
    logic       exp_last;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] stream [N];
  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  int         stall_cnt = 0;
  triangle_t  out_tri_q [$];
  logic       out_last_q [$];
  int         out_cyc_q [$];
  triangle_t  exp_tri_q [$];
  logic       exp_last_q [$];

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  // Output-handshake and input-stall monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rstn === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      out_tri_q.push_back(m_triangle);
      out_last_q.push_back(m_metadata.last);
      out_cyc_q.push_back(cycle);
    end
    if (rstn === 1'b1 && s_valid === 1'b1 && s_ready !== 1'b1 && flush === 1'b0)
      stall_cnt = stall_cnt + 1;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic triangle_t make_tri(input logic [31:0] seed);
    vertex_t v [3];
    for (int i = 0; i < 3; i++) begin
      v[i].position.x  = seed + 32'h0102_0304 * 32'(3 * i + 1);
      v[i].position.y  = seed + 32'h0102_0304 * 32'(3 * i + 2);
      v[i].position.z  = seed + 32'h0102_0304 * 32'(3 * i + 3);
      v[i].color.red   = seed[3:0] + 4'(i);
      v[i].color.green = seed[7:4] ^ 4'(i);
      v[i].color.blue  = seed[11:8] - 4'(i);
    end
    return triangle_t'{v0: v[0], v1: v[1], v2: v[2]};
  endfunction

  function automatic vertex_t get_vtx(input triangle_t t, input int i);
    case (i)
      0:       return t.v0;
      1:       return t.v1;
      default: return t.v2;
    endcase
  endfunction

  // Serialise one record into the wire byte order.
  task automatic encode(input vec_t v);
    int idx = 0;
    vertex_t vx;
    logic [31:0] val;
    logic [15:0] word;
    for (int vi = 0; vi < 3; vi++) begin
      vx = get_vtx(v.tri_in, vi);
      for (int c = 0; c < 3; c++) begin
        val = (c == 0) ? vx.position.x : (c == 1) ? vx.position.y : vx.position.z;
        for (int b = 0; b < 4; b++) begin
          stream[idx] = val[b*8 +: 8];
          idx++;
        end
      end
      word = {v.col_junk, vx.color.red, vx.color.green, vx.color.blue};
      stream[idx] = word[7:0];
      stream[idx+1] = word[15:8];
      idx += 2;
    end
    stream[idx] = {v.flag_junk, v.last_in};
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int guard = 0;
    logic ok;
    while (int'($urandom_range(99, 0)) < gap_pct) begin
      s_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_data  = b;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0h never accepted", b);
        break;
      end
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_pct);
    for (int i = lo; i <= hi; i++) send_byte(stream[i], gap_pct);
    s_valid = 1'b0;
  endtask

  task automatic send_tri(input vec_t v, input int gap_pct, input bit expect_out);
    encode(v);
    if (expect_out) begin
      exp_tri_q.push_back(v.exp_tri);
      exp_last_q.push_back(v.exp_last);
    end
    send_range(0, N - 1, gap_pct);
  endtask

  task automatic drain_check(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, 512'(out_tri_q.size()), 512'(exp_tri_q.size()));
    while (out_tri_q.size() > 0 && exp_tri_q.size() > 0) begin
      chk({tag, "_tri"}, 512'(out_tri_q.pop_front()), 512'(exp_tri_q.pop_front()));
      chk({tag, "_last"}, 512'(out_last_q.pop_front()), 512'(exp_last_q.pop_front()));
    end
    out_tri_q.delete();
    out_last_q.delete();
    exp_tri_q.delete();
    exp_last_q.delete();
  endtask

  initial begin
    logic [31:0] seeds [8];
    int gap_free_cyc;
    seeds = '{32'hA5A5_0F1E, 32'h1357_9BDF, 32'h2468_ACE0, 32'hDEAD_BEEF,
              32'hCAFE_F00D, 32'h0BAD_C0DE, 32'h7777_1111, 32'h0F0F_F0F0};
    for (int i = 0; i < 8; i++) begin
      vecs[i].tri_in    = make_tri(seeds[i]);
      vecs[i].col_junk  = 4'(i * 5 + 3);
      vecs[i].flag_junk = 7'h55 ^ 7'(i);
      vecs[i].last_in   = i[0];
    end
    vecs[0].tri_in.v0.position.x = 32'h1234_5678;
    vecs[0].tri_in.v2.color      = color_t'{red: 4'h3, green: 4'h2, blue: 4'h1};
    vecs[0].col_junk             = 4'hF;
    vecs[0].flag_junk            = 7'h00;
    vecs[0].last_in              = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vecs[i].exp_tri  = vecs[i].tri_in;
      vecs[i].exp_last = vecs[i].last_in;
    end

    rstn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 512'(s_ready), 512'(1'b1));
    chk("rst_m_valid", 512'(m_valid), 512'(1'b0));
    chk("rst_m_triangle", 512'(m_triangle), 512'(0));
    chk("rst_m_metadata", 512'(m_metadata), 512'(0));
    chk("rst_busy", 512'(busy), 512'(1'b0));
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Field mapping: bytes 78 56 34 12 for v0.x, color word 21 F3 for v2, flag 01.
    send_tri(vecs[0], 0, 1'b1);
    @(negedge clk);
    chk("fm_m_valid", 512'(m_valid), 512'(1'b1));
    chk("fm_v0_x", 512'(m_triangle.v0.position.x), 512'(32'h1234_5678));
    chk("fm_v2_red", 512'(m_triangle.v2.color.red), 512'(4'h3));
    chk("fm_v2_green", 512'(m_triangle.v2.color.green), 512'(4'h2));
    chk("fm_v2_blue", 512'(m_triangle.v2.color.blue), 512'(4'h1));
    chk("fm_last", 512'(m_metadata.last), 512'(1'b1));
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    drain_check("fm");

    // Back-to-back throughput.
    stall_cnt = 0;
    out_cyc_q.delete();
    send_tri(vecs[1], 0, 1'b1);
    send_tri(vecs[2], 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_stalls", 512'(stall_cnt), 512'(0));
    chk("b2b_pulses", 512'(out_cyc_q.size()), 512'(2));
    gap_free_cyc = (out_cyc_q.size() == 2) ? out_cyc_q[1] - out_cyc_q[0] : -1;
    chk("b2b_spacing", 512'(gap_free_cyc), 512'(N));
    drain_check("b2b");

    // Backpressure: output held, next body flows, flag waits for drain.
    m_ready = 1'b0;
    send_tri(vecs[3], 0, 1'b1);
    stall_cnt = 0;
    encode(vecs[4]);
    exp_tri_q.push_back(vecs[4].exp_tri);
    exp_last_q.push_back(vecs[4].exp_last);
    send_range(0, N - 2, 0);
    chk("bp_body_stalls", 512'(stall_cnt), 512'(0));
    s_data = stream[N-1];
    s_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_flag_held", 512'(s_ready), 512'(1'b0));
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_flag_ready", 512'(s_ready), 512'(1'b1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    chk("bp_m_valid_kept", 512'(m_valid), 512'(1'b1));
    chk("bp_second_tri", 512'(m_triangle), 512'(vecs[4].exp_tri));
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    drain_check("bp");

    // Flush after 10 bytes.
    encode(vecs[5]);
    send_range(0, 9, 0);
    @(negedge clk);
    chk("fl_busy_before", 512'(busy), 512'(1'b1));
    @(posedge clk);
    #1;
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = stream[10];
    @(negedge clk);
    chk("fl_s_ready", 512'(s_ready), 512'(1'b0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("fl_busy_after", 512'(busy), 512'(1'b0));
    @(posedge clk);
    #1;
    send_tri(vecs[5], 0, 1'b1);
    drain_check("fl");

    // Reset with a pending output and 20 bytes of the next triangle.
    m_ready = 1'b0;
    send_tri(vecs[6], 0, 1'b0);
    encode(vecs[7]);
    send_range(0, 19, 0);
    @(negedge clk);
    chk("rm_pending", 512'(m_valid), 512'(1'b1));
    chk("rm_busy_pre", 512'(busy), 512'(1'b1));
    rstn = 1'b0;
    @(negedge clk);
    chk("rm_m_valid", 512'(m_valid), 512'(1'b0));
    chk("rm_busy", 512'(busy), 512'(1'b0));
    chk("rm_m_triangle", 512'(m_triangle), 512'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m_ready = 1'b1;
    send_tri(vecs[7], 0, 1'b1);
    drain_check("rm");

    // Random 50% gaps on s_valid; results must match the gap-free triangles.
    send_tri(vecs[1], 50, 1'b1);
    send_tri(vecs[2], 50, 1'b1);
    send_tri(vecs[0], 50, 1'b1);
    drain_check("gap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
